// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: IM req/gnt/rvalid port, redirect inputs and the ID-facing head handshake.
// With IF_PERF_CNT_EN defined the three performance counter outputs are added to the master modport.
interface if_fetch_queue_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic [1:0]        BranchCtrl;
  logic [ADDR_W-1:0] PC_imm;
  logic [ADDR_W-1:0] PC_jr;
  logic              id_ready;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [XLEN-1:0]   imem_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [XLEN-1:0]   if_instr;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_stall_cnt;

  modport master (
    input  BranchCtrl, PC_imm, PC_jr, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    output perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt
  );
  modport slave (
    output BranchCtrl, PC_imm, PC_jr, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt
  );
`else
  modport master (
    input  BranchCtrl, PC_imm, PC_jr, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );
  modport slave (
    output BranchCtrl, PC_imm, PC_jr, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
`endif
endinterface

// File: rtl/if_fetch_queue.sv
// RV32 fetch queue: pipelined IM reads into a QDEPTH FIFO, gnt-cycle response visible at ID next cycle;
// issue stops when outstanding+queued reaches QDEPTH or MAX_OUT. IF_PERF_CNT_EN adds perf counters.
module if_fetch_queue #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  if_fetch_queue_if.master bus
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [PW-1:0]     q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [PW-1:0]     pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;

  logic [ADDR_W-1:0] q_pc_q    [QDEPTH];
  logic [XLEN-1:0]   q_instr_q [QDEPTH];
  logic [ADDR_W-1:0] pcf_q     [QDEPTH];

  logic              redirect, req, issue, resp, resp_drop, push, pop, head_vld;
  logic [ADDR_W-1:0] target;
  logic [CW:0]       occ;

  always_comb begin
    redirect  = (bus.BranchCtrl == 2'b01) || (bus.BranchCtrl == 2'b10);
    target    = (bus.BranchCtrl == 2'b10) ? bus.PC_jr : bus.PC_imm;
    occ       = {1'b0, outstanding_q} + {1'b0, count_q};
    req       = !rst && !redirect && (outstanding_q < CW'(MAX_OUT)) && (occ < (CW+1)'(QDEPTH));
    issue     = req && bus.imem_gnt;
    resp      = bus.imem_rvalid;
    resp_drop = resp && (redirect || (drop_q != '0));
    push      = resp && !resp_drop;
    head_vld  = !rst && (count_q != '0);
    pop       = head_vld && bus.id_ready && !redirect;

    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = target;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end

    outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
    // The PC FIFO tracks every in-flight request, so dropped responses still consume their entry.
    pcf_wr_d = pcf_wr_q + PW'(issue);
    pcf_rd_d = pcf_rd_q + PW'(resp);

    if (redirect) begin
      // Every request still in flight after this cycle is stale, including ones already doomed.
      drop_d  = outstanding_q - CW'(resp);
      count_d = '0;
      q_wr_d  = '0;
      q_rd_d  = '0;
    end else begin
      drop_d  = drop_q - CW'(resp && (drop_q != '0));
      count_d = count_q + CW'(push) - CW'(pop);
      q_wr_d  = q_wr_q + PW'(push);
      q_rd_d  = q_rd_q + PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      drop_q        <= '0;
      q_wr_q        <= '0;
      q_rd_q        <= '0;
      pcf_wr_q      <= '0;
      pcf_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
      pcf_wr_q      <= pcf_wr_d;
      pcf_rd_q      <= pcf_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      pcf_q[pcf_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      q_pc_q[q_wr_q]    <= pcf_q[pcf_rd_q];
      q_instr_q[q_wr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = head_vld;
  assign bus.if_pc     = head_vld ? q_pc_q[q_rd_q] : '0;
  assign bus.if_instr  = head_vld ? q_instr_q[q_rd_q] : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_drop_q, perf_drop_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [32:0] drop_sum;

  always_comb begin
    // A redirect flushes count_q entries on top of any discarded response.
    drop_sum     = {1'b0, perf_drop_q} + 33'(resp_drop) + (redirect ? 33'(count_q) : 33'd0);
    perf_drop_d  = drop_sum[32] ? '1 : drop_sum[31:0];
    perf_fetch_d = (issue && (perf_fetch_q != '1)) ? perf_fetch_q + 32'd1 : perf_fetch_q;
    perf_stall_d = (head_vld && !bus.id_ready && (perf_stall_q != '1)) ? perf_stall_q + 32'd1
                                                                        : perf_stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_drop_q  <= perf_drop_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_q;
  assign bus.perf_drop_cnt  = perf_drop_q;
  assign bus.perf_stall_cnt = perf_stall_q;
`endif

  a_credit: assert property (@(posedge clk) disable iff (rst) occ <= (CW+1)'(QDEPTH));
  a_max_out: assert property (@(posedge clk) disable iff (rst) outstanding_q <= CW'(MAX_OUT));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order, variable-latency instruction memory model.
module tb_if_fetch_queue;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) fq_if ();

  if_fetch_queue #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fq_if)
  );

  int total = 0;
  int bad   = 0;

  int cyc      = 0;
  int lat_lo   = 1;
  int lat_hi   = 1;
  bit gnt_rand = 1'b0;
  int last_due = 0;
  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_due[$];

  function automatic logic [XLEN-1:0] mem(input logic [ADDR_W-1:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // IM model: responses in request order, at least lat cycles after the grant cycle.
  initial begin
    int due;
    fq_if.imem_gnt    = 1'b0;
    fq_if.imem_rvalid = 1'b0;
    fq_if.imem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        fq_if.imem_rvalid = 1'b1;
        fq_if.imem_rdata  = mem(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        fq_if.imem_rvalid = 1'b0;
        fq_if.imem_rdata  = '0;
      end
      fq_if.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst) begin
        pend_due.delete();
        pend_addr.delete();
      end else if (fq_if.imem_req && fq_if.imem_gnt) begin
        due = cyc + int'($urandom_range(lat_lo, lat_hi));
        if (pend_due.size() > 0 && due <= last_due) due = last_due + 1;
        pend_due.push_back(due);
        pend_addr.push_back(fq_if.imem_addr);
        last_due = due;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    fq_if.BranchCtrl = 2'b00;
    fq_if.PC_imm     = '0;
    fq_if.PC_jr      = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fq_if.id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", fq_if.imem_req); end
    total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fq_if.if_valid); end
    total++; if (fq_if.if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", fq_if.if_pc); end
    total++; if (fq_if.if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", fq_if.if_instr); end
    total++; if (fq_if.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", fq_if.imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    fq_if.id_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ea = 32'(4 * k);
      total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== ea) begin
        bad++; $display("FAIL stream_issue c%0d got=%b/%h exp=1/%h", k, fq_if.imem_req, fq_if.imem_addr, ea);
      end
      if (k >= 2) begin
        ep = 32'(4 * (k - 2));
        total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== ep) begin
          bad++; $display("FAIL stream_head c%0d got=%b/%h exp=1/%h", k, fq_if.if_valid, fq_if.if_pc, ep);
        end
        total++; if (fq_if.if_instr !== mem(ep)) begin
          bad++; $display("FAIL stream_instr c%0d got=%h exp=%h", k, fq_if.if_instr, mem(ep));
        end
      end else begin
        total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL stream_early c%0d got=%b exp=0", k, fq_if.if_valid); end
      end
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", fq_if.if_valid); end
    total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", fq_if.imem_req); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 32'h0) begin
      bad++; $display("FAIL midrst_addr got=%b/%h exp=1/0", fq_if.imem_req, fq_if.imem_addr);
    end
    total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL midrst_empty got=%b exp=0", fq_if.if_valid); end
    repeat (2) @(negedge clk);
    total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== 32'h0) begin
      bad++; $display("FAIL midrst_first got=%b/%h exp=1/0", fq_if.if_valid, fq_if.if_pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ep;
    gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    fq_if.id_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 10) begin
        @(posedge clk); #1;
        fq_if.id_ready = 1'b1;
      end
      @(negedge clk);
      if (k < 10) begin
        total++; if (fq_if.imem_req !== (k < 4)) begin
          bad++; $display("FAIL stall_req c%0d got=%b exp=%b", k, fq_if.imem_req, (k < 4));
        end
        if (k >= 2) begin
          total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== 32'h0) begin
            bad++; $display("FAIL stall_hold c%0d got=%b/%h exp=1/0", k, fq_if.if_valid, fq_if.if_pc);
          end
        end
      end else begin
        ep = 32'(4 * (k - 10));
        total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== ep || fq_if.if_instr !== mem(ep)) begin
          bad++; $display("FAIL stall_drain c%0d got=%b/%h/%h exp=1/%h/%h", k, fq_if.if_valid,
                          fq_if.if_pc, fq_if.if_instr, ep, mem(ep));
        end
      end
`ifdef IF_PERF_CNT_EN
      if (k == 10) begin
        total++; if (fq_if.perf_stall_cnt !== 32'd8) begin
          bad++; $display("FAIL perf_stall got=%0d exp=8", fq_if.perf_stall_cnt);
        end
      end
`endif
    end
  endtask

  task automatic test_redirect_imm();
    bit found;
    gnt_rand = 1'b0; lat_lo = 3; lat_hi = 3;
    fq_if.id_ready = 1'b1;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    fq_if.BranchCtrl = 2'b01;
    fq_if.PC_imm     = 32'h100;
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL rimm_req got=%b exp=0", fq_if.imem_req); end
    @(posedge clk); #1;
    fq_if.BranchCtrl = 2'b00;
    @(negedge clk);
    total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL rimm_empty got=%b exp=0", fq_if.if_valid); end
    total++; if (fq_if.imem_addr !== 32'h100) begin bad++; $display("FAIL rimm_addr got=%h exp=100", fq_if.imem_addr); end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = fq_if.if_valid;
    end
    total++; if (!found) begin bad++; $display("FAIL rimm_timeout got=no_entry exp=entry"); end
    total++; if (fq_if.if_pc !== 32'h100 || fq_if.if_instr !== mem(32'h100)) begin
      bad++; $display("FAIL rimm_first got=%h/%h exp=100/%h", fq_if.if_pc, fq_if.if_instr, mem(32'h100));
    end
  endtask

  task automatic test_redirect_jr();
    gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    fq_if.id_ready = 1'b1;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    fq_if.BranchCtrl = 2'b10;
    fq_if.PC_jr      = 32'h200;
    fq_if.PC_imm     = 32'h700;
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL rjr_req got=%b exp=0", fq_if.imem_req); end
    total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== 32'h4) begin
      bad++; $display("FAIL rjr_head got=%b/%h exp=1/4", fq_if.if_valid, fq_if.if_pc);
    end
    @(posedge clk); #1;
    fq_if.BranchCtrl = 2'b00;
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 32'h200) begin
      bad++; $display("FAIL rjr_addr got=%b/%h exp=1/200", fq_if.imem_req, fq_if.imem_addr);
    end
    total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL rjr_flush got=%b exp=0", fq_if.if_valid); end
`ifdef IF_PERF_CNT_EN
    total++; if (fq_if.perf_drop_cnt !== 32'd2) begin bad++; $display("FAIL perf_drop got=%0d exp=2", fq_if.perf_drop_cnt); end
`endif
    @(negedge clk);
    total++; if (fq_if.if_valid !== 1'b0) begin bad++; $display("FAIL rjr_stale got=%b/%h exp=0", fq_if.if_valid, fq_if.if_pc); end
    @(negedge clk);
    total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== 32'h200 || fq_if.if_instr !== mem(32'h200)) begin
      bad++; $display("FAIL rjr_first got=%b/%h/%h exp=1/200/%h", fq_if.if_valid, fq_if.if_pc,
                      fq_if.if_instr, mem(32'h200));
    end
  endtask

  task automatic test_wrap();
    gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    fq_if.id_ready = 1'b1;
    do_reset();
    fq_if.BranchCtrl = 2'b01;
    fq_if.PC_imm     = 32'hFFFF_FFFC;
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b0) begin bad++; $display("FAIL wrap_redir_req got=%b exp=0", fq_if.imem_req); end
    @(posedge clk); #1;
    fq_if.BranchCtrl = 2'b00;
    @(negedge clk);
    total++; if (fq_if.imem_req !== 1'b1 || fq_if.imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", fq_if.imem_req, fq_if.imem_addr);
    end
    @(negedge clk);
    total++; if (fq_if.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", fq_if.imem_addr); end
    @(negedge clk);
    total++; if (fq_if.if_pc !== 32'hFFFF_FFFC || fq_if.if_instr !== mem(32'hFFFF_FFFC)) begin
      bad++; $display("FAIL wrap_head got=%h/%h exp=fffffffc/%h", fq_if.if_pc, fq_if.if_instr, mem(32'hFFFF_FFFC));
    end
    @(negedge clk);
    total++; if (fq_if.if_valid !== 1'b1 || fq_if.if_pc !== 32'h0) begin
      bad++; $display("FAIL wrap_next got=%b/%h exp=1/0", fq_if.if_valid, fq_if.if_pc);
    end
`ifdef IF_PERF_CNT_EN
    total++; if (fq_if.perf_fetch_cnt !== 32'd3) begin bad++; $display("FAIL perf_fetch got=%0d exp=3", fq_if.perf_fetch_cnt); end
    total++; if (fq_if.perf_drop_cnt !== 32'd0) begin bad++; $display("FAIL perf_nodrop got=%0d exp=0", fq_if.perf_drop_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int tally, got;
    gnt_rand = 1'b1; lat_lo = 1; lat_hi = 5;
    fq_if.id_ready = 1'b0;
    do_reset();
    exp_pc = 32'h0; tally = 0; got = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      total++; if (tally > MAX_OUT) begin bad++; $display("FAIL rand_outstanding c%0d got=%0d exp<=%0d", i, tally, MAX_OUT); end
      if (fq_if.if_valid && fq_if.id_ready) begin
        total++; if (fq_if.if_pc !== exp_pc || fq_if.if_instr !== mem(exp_pc)) begin
          bad++; $display("FAIL rand_seq c%0d got=%h/%h exp=%h/%h", i, fq_if.if_pc, fq_if.if_instr, exp_pc, mem(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tally = tally + int'(fq_if.imem_req && fq_if.imem_gnt) - int'(fq_if.imem_rvalid);
      @(posedge clk); #1;
      fq_if.id_ready = 1'($urandom_range(0, 1));
    end
    total++; if (got < 500) begin bad++; $display("FAIL rand_progress got=%0d exp>=500", got); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fq_if.BranchCtrl = 2'b00;
    fq_if.PC_imm     = '0;
    fq_if.PC_jr      = '0;
    fq_if.id_ready   = 1'b0;
    test_reset();
    test_stream();
    test_mid_reset();
    test_stall();
    test_redirect_imm();
    test_redirect_jr();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
